// File: rtl/axis_byte_serializer_pkg.sv
// Shared types and helpers for the AXI-stream byte serializer and related framers.
// Holds the FSM state encoding and 4-lane mask helpers.
package axis_byte_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [1:0] lowest_lane(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [3:0] mask);
    return (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/axis_gap_timer.sv
// Loadable down-counter: start loads GAP_CYCLES-1, done is high while the count is zero.
// Holding the owner in its gap state until done yields exactly GAP_CYCLES cycles.
module axis_gap_timer #(
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int unsigned W = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [W-1:0] LOAD = (GAP_CYCLES == 0) ? '0 : W'(GAP_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/axis_byte_serializer.sv
// Serializes 32-bit AXI-stream beats into an 8-bit byte stream, lane 0 first,
// and forces an idle gap after each packet so a timeout-based parser can delimit it.
module axis_byte_serializer
  import axis_byte_serializer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 i_tready,
  input  logic                 i_tvalid,
  input  logic [31:0]          i_tdata,
  input  logic [3:0]           i_tkeep,
  input  logic                 i_tlast,
  input  logic                 o_tready,
  output logic                 o_tvalid,
  output logic [7:0]           o_tdata,
  output logic                 o_tlast,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_pkt_count,
  output logic                 o_err_nolast
);

  localparam state_e AFTER_PKT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_e               state_q, state_d;
  logic [31:0]          data_q, data_d;
  logic [3:0]           mask_q, mask_d;
  logic                 last_q, last_d;
  logic                 rdy_q, rdy_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic                 err_q, err_d;
  logic                 gap_start, gap_done;
  logic [1:0]           lane;
  logic [3:0]           mask_left;

  assign lane      = lowest_lane(mask_q);
  assign mask_left = mask_q & ~(4'b0001 << lane);

  axis_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .start (gap_start),
    .done  (gap_done)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    last_d      = last_q;
    pkt_count_d = pkt_count_q;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_tvalid && rdy_q) begin
          data_d = i_tdata;
          mask_d = i_tkeep;
          last_d = i_tlast;
          if (i_tkeep != 4'd0) begin
            state_d = ST_SEND;
          end else if (i_tlast) begin
            // Packet closed by an empty beat: still counted, flagged as an error.
            err_d       = 1'b1;
            pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
            state_d     = AFTER_PKT;
          end
        end
      end
      ST_SEND: begin
        if (o_tready) begin
          mask_d = mask_left;
          if (mask_left == 4'd0) begin
            if (last_q) begin
              pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
              state_d     = AFTER_PKT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gap_start = (state_d == ST_GAP) && (state_q != ST_GAP);
  assign rdy_d     = (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      mask_q      <= '0;
      last_q      <= 1'b0;
      rdy_q       <= 1'b0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      last_q      <= last_d;
      rdy_q       <= rdy_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

  // Handshake: a transfer occurs on any rising edge where valid and ready are both high;
  // o_tvalid, once high, stays high with stable data until that edge.
  assign i_tready     = rdy_q;
  assign o_tvalid     = (state_q == ST_SEND);
  assign o_tdata      = (state_q == ST_SEND) ? data_q[{lane, 3'b000} +: 8] : 8'd0;
  assign o_tlast      = (state_q == ST_SEND) && last_q && single_bit(mask_q);
  assign o_busy       = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign o_pkt_count  = pkt_count_q;
  assign o_err_nolast = err_q;

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Bench for axis_byte_serializer: directed and random beats, expected bytes queued at issue,
// a negedge monitor compares every output byte, gap length, hold stability and error pulses.
module tb_axis_byte_serializer;

  localparam int GAP = 4;

  logic        clk;
  logic        rst;
  logic        i_tready;
  logic        i_tvalid;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        i_tlast;
  logic        o_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        o_busy;
  logic [15:0] o_pkt_count;
  logic        o_err_nolast;

  int assertions = 0;
  int failures   = 0;
  int exp_pkts   = 0;
  int exp_err    = 0;
  int err_seen   = 0;
  int gap_len    = 0;
  bit measuring  = 0;
  bit prev_stall = 0;
  bit bp_en      = 0;
  logic [8:0] prev_byte;
  logic [8:0] exp_q[$];

  axis_byte_serializer #(.GAP_CYCLES(GAP), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_tready     (i_tready),
    .i_tvalid     (i_tvalid),
    .i_tdata      (i_tdata),
    .i_tkeep      (i_tkeep),
    .i_tlast      (i_tlast),
    .o_tready     (o_tready),
    .o_tvalid     (o_tvalid),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_busy       (o_busy),
    .o_pkt_count  (o_pkt_count),
    .o_err_nolast (o_err_nolast)
  );

  // Clock and downstream ready
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: kept lanes in ascending order, tlast on the highest kept lane of a last beat.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited;
    for (int b = 0; b < 4; b++) begin
      if (k[b]) exp_q.push_back({(l && ((k >> (b + 1)) == 4'd0)), d[8*b +: 8]});
    end
    if (l) exp_pkts++;
    if (l && k == 4'd0) exp_err++;
    @(negedge clk);
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tkeep  = k;
    i_tlast  = l;
    waited   = 0;
    while (!i_tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", {31'd0, i_tready}, 32'd1);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !i_tready || measuring) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && i_tready && !measuring)}, 32'd1);
    check("pkt_count", {16'd0, o_pkt_count}, exp_pkts & 32'hFFFF);
    check("err_count", err_seen, exp_err);
  endtask

  // Monitor: byte scoreboard, hold stability under backpressure, post-packet gap length
  always @(negedge clk) begin
    if (rst) begin
      measuring  = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, o_tvalid}, 32'd1);
        check("hold_byte", {23'd0, o_tlast, o_tdata}, {23'd0, prev_byte});
      end
      if (measuring) begin
        if (!i_tready) begin
          gap_len++;
        end else begin
          check("gap_len", gap_len, GAP);
          measuring = 0;
        end
      end
      if (o_err_nolast) begin
        err_seen++;
        measuring = 1;
        gap_len   = 1;
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          assertions++;
          failures++;
          $display("FAIL extra_byte: got %0h expected no byte at %0t", {o_tlast, o_tdata}, $time);
        end else begin
          check("byte", {23'd0, o_tlast, o_tdata}, {23'd0, exp_q.pop_front()});
        end
        if (o_tlast) begin
          measuring = 1;
          gap_len   = 0;
        end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_byte  = {o_tlast, o_tdata};
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    i_tvalid = 1'b0;
    i_tdata  = '0;
    i_tkeep  = '0;
    i_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("rst_tdata", {24'd0, o_tdata}, 32'd0);
    check("rst_tlast", {31'd0, o_tlast}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_pkt_count", {16'd0, o_pkt_count}, 32'd0);
    check("rst_err", {31'd0, o_err_nolast}, 32'd0);
    check("rst_tready", {31'd0, i_tready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single full beat: bytes on consecutive cycles starting the cycle after acceptance
    send_beat(32'h44332211, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_consecutive_valid", {31'd0, o_tvalid}, 32'd1);
    end
    drain();

    // Two-beat packet with partial last beat
    send_beat(32'h0A0B0C0D, 4'hF, 1'b0);
    send_beat(32'h00001F2E, 4'h3, 1'b1);
    drain();

    // Non-contiguous keep
    send_beat(32'hDDCCBBAA, 4'b1010, 1'b1);
    drain();

    // Backpressure over a 3-beat packet
    bp_en = 1;
    send_beat(32'h13579BDF, 4'hF, 1'b0);
    send_beat(32'h2468ACE0, 4'b0110, 1'b0);
    send_beat(32'hCAFEF00D, 4'hF, 1'b1);
    drain();
    bp_en = 0;

    // Zero-keep beats: dropped, then packet-ending error
    send_beat(32'hDEADBEEF, 4'h0, 1'b0);
    @(negedge clk);
    check("drop_stays_idle", {31'd0, i_tready}, 32'd1);
    check("drop_no_valid", {31'd0, o_tvalid}, 32'd0);
    send_beat(32'hFEEDFACE, 4'h0, 1'b1);
    @(negedge clk);
    check("err_pulse_hi", {31'd0, o_err_nolast}, 32'd1);
    check("err_busy", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    check("err_pulse_lo", {31'd0, o_err_nolast}, 32'd0);
    drain();

    // Reset with two bytes still pending
    send_beat(32'h87654321, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_pending", exp_q.size(), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_pkts = 0;
    @(negedge clk);
    check("mid_rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_pkt_count", {16'd0, o_pkt_count}, 32'd0);
    send_beat(32'h5A6B7C8D, 4'hF, 1'b1);
    drain();

    // Random beats with random backpressure
    bp_en = 1;
    for (int i = 0; i < 24; i++) begin
      send_beat($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
    end
    send_beat($urandom, 4'hF, 1'b1);
    drain();
    bp_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
